// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and immediate extension.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluCtrl_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } immSrc_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_t;

  // IMM_NONE yields zero so NOPs and R-type carry a clean immediate field.
  function automatic logic [31:0] immExtend(input logic [31:0] instr, input immSrc_t immSrc);
    logic [31:0] imm;
    imm = '0;
    case (immSrc)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational reads, one clocked write, x0 hardwired zero.
module reg_file import riscv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wrLive;

  assign wrLive = we && (wa != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrLive) begin
      regs[wa] <= wd;
    end
  end

  // Write-through so a dependent instruction decoded during writeback sees the new value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (wrLive && wa == ra1) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (wrLive && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension and the ID/EX register.
module decode_cycle import riscv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD, useAluFunct;
  resultSrc_t      resultSrcD;
  aluCtrl_t        aluControlD;
  immSrc_t         immSrcD;
  logic [XLEN-1:0] rd1D, rd2D, immExtD;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  always_comb begin
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    useAluFunct = 1'b0;
    resultSrcD  = RES_ALU;
    aluControlD = ALU_ADD;
    immSrcD     = IMM_NONE;
    case (opcode)
      OP_LW:  begin regWriteD = 1'b1; aluSrcD = 1'b1; resultSrcD = RES_MEM; immSrcD = IMM_I; end
      OP_SW:  begin memWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_S; end
      OP_R:   begin regWriteD = 1'b1; useAluFunct = 1'b1; end
      OP_I:   begin regWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_I; useAluFunct = 1'b1; end
      OP_BEQ: begin branchD = 1'b1; immSrcD = IMM_B; aluControlD = ALU_SUB; end
      OP_JAL: begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = RES_PC4; immSrcD = IMM_J; end
      default: ;
    endcase
    // funct7[5] only selects sub for R-type; in I-ALU that bit belongs to the immediate.
    if (useAluFunct) begin
      case (funct3)
        3'b000:  aluControlD = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  aluControlD = ALU_SLT;
        3'b110:  aluControlD = ALU_OR;
        3'b111:  aluControlD = ALU_AND;
        default: aluControlD = ALU_ADD;
      endcase
    end
  end

  assign immExtD = immExtend(InstrD, immSrcD);

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) uRegFile (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .rd1 (rd1D),
    .rd2 (rd2D)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= regWriteD;
      MemWriteE   <= memWriteD;
      JumpE       <= jumpD;
      BranchE     <= branchD;
      ALUSrcE     <= aluSrcD;
      ResultSrcE  <= resultSrcD;
      ALUControlE <= aluControlD;
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      ImmExtE     <= immExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[11:7];
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: hand-computed ID/EX contents checked one cycle after each decode.
module tb_decode_cycle;

  typedef struct packed {
    logic        regWrite, memWrite, jump, branch, aluSrc;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } eBus_t;
  localparam int EW = $bits(eBus_t);

  logic        clk, rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
  endtask

  task automatic writeback(input logic we, input logic [4:0] rd, input logic [31:0] data);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  function automatic eBus_t mk(input logic [9:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    eBus_t e;
    {e.regWrite, e.memWrite, e.jump, e.branch, e.aluSrc, e.resultSrc, e.aluControl} = ctrl;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pc; e.pc4 = pc + 32'd4;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    return e;
  endfunction

  function automatic eBus_t bubble();
    eBus_t e;
    e = '0;
    return e;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic checkE(input string tag);
    eBus_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = eBus_t'(exp_q.pop_front());
      chk(tag, "ctrl", {22'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE},
          {22'd0, e.regWrite, e.memWrite, e.jump, e.branch, e.aluSrc, e.resultSrc, e.aluControl});
      chk(tag, "RD1E", RD1E, e.rd1);
      chk(tag, "RD2E", RD2E, e.rd2);
      chk(tag, "ImmExtE", ImmExtE, e.imm);
      chk(tag, "PCE", PCE, e.pc);
      chk(tag, "PCPlus4E", PCPlus4E, e.pc4);
      chk(tag, "regs", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, e.rs1, e.rs2, e.rd});
    end
  endtask

  task automatic applyCheck(input string tag, input eBus_t e);
    exp_q.push_back(EW'(e));
    step();
    checkE(tag);
  endtask

  initial begin
    rst = 1'b1;
    FlushE = 1'b0;
    writeback(1'b0, 5'd0, 32'd0);
    drive(32'd0, 32'd0);
    PCPlus4D = 32'd0;
    #1;
    exp_q.push_back(EW'(bubble()));
    checkE("reset_async");
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) applyCheck("post_reset_nop", bubble());

    // x5 = 0x1234, then add x6,x5,x5
    writeback(1'b1, 5'd5, 32'h0000_1234);
    applyCheck("wb_x5", mk(10'b0_0_0_0_0_00_000, 0, 0, 0, 32'h0, 0, 0, 0) ^ EW'(0) | EW'(0) ? bubble() : bubble());
    writeback(1'b0, 5'd0, 32'd0);
    drive(32'h0052_8333, 32'h100);
    #1;
    chk("add", "Rs1D", {27'd0, Rs1D}, 32'd5);
    chk("add", "Rs2D", {27'd0, Rs2D}, 32'd5);
    applyCheck("add", mk(10'b1_0_0_0_0_00_000, 32'h1234, 32'h1234, 0, 32'h100, 5, 5, 6));

    // same-cycle writeback of x7 while sw x7,-4(x7) decodes
    writeback(1'b1, 5'd7, 32'hDEAD_BEEF);
    drive(32'hFE73_AE23, 32'h104);
    applyCheck("sw_bypass", mk(10'b0_1_0_0_1_00_000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h104, 7, 7, 28));
    writeback(1'b0, 5'd0, 32'd0);

    drive(32'h0043_A403, 32'h108);
    applyCheck("lw", mk(10'b1_0_0_0_1_01_000, 32'hDEAD_BEEF, 0, 32'h4, 32'h108, 7, 4, 8));
    drive(32'h4072_84B3, 32'h10C);
    applyCheck("sub", mk(10'b1_0_0_0_0_00_001, 32'h1234, 32'hDEAD_BEEF, 0, 32'h10C, 5, 7, 9));
    drive(32'h0072_F5B3, 32'h110);
    applyCheck("and", mk(10'b1_0_0_0_0_00_010, 32'h1234, 32'hDEAD_BEEF, 0, 32'h110, 5, 7, 11));
    drive(32'h0012_A513, 32'h114);
    applyCheck("slti", mk(10'b1_0_0_0_1_00_101, 32'h1234, 0, 32'h1, 32'h114, 5, 1, 10));
    drive(32'hC000_0193, 32'h118);
    applyCheck("addi_neg", mk(10'b1_0_0_0_1_00_000, 0, 0, 32'hFFFF_FC00, 32'h118, 0, 0, 3));
    drive(32'hFE20_8CE3, 32'h11C);
    applyCheck("beq", mk(10'b0_0_0_1_0_00_001, 0, 0, 32'hFFFF_FFF8, 32'h11C, 1, 2, 25));
    drive(32'h0010_00EF, 32'h120);
    applyCheck("jal", mk(10'b1_0_1_0_0_10_000, 0, 0, 32'h800, 32'h120, 0, 1, 1));

    // writes to x0 are dropped, even in the same cycle as a read of x0
    writeback(1'b1, 5'd0, 32'h0000_FFFF);
    drive(32'h0000_0333, 32'h124);
    applyCheck("x0_same_cycle", mk(10'b1_0_0_0_0_00_000, 0, 0, 0, 32'h124, 0, 0, 6));
    writeback(1'b0, 5'd0, 32'd0);
    drive(32'h0000_0333, 32'h128);
    applyCheck("x0_after", mk(10'b1_0_0_0_0_00_000, 0, 0, 0, 32'h128, 0, 0, 6));

    drive(32'hFFFF_FFFF, 32'h12C);
    #1;
    chk("unknown", "Rs1D", {27'd0, Rs1D}, 32'd31);
    applyCheck("unknown_op", mk(10'b0_0_0_0_0_00_000, 0, 0, 0, 32'h12C, 31, 31, 31));

    FlushE = 1'b1;
    drive(32'h0050_0193, 32'h130);
    applyCheck("flush", bubble());
    FlushE = 1'b0;

    // asynchronous reset mid-stream
    drive(32'h0052_8333, 32'h134);
    applyCheck("add_pre_rst", mk(10'b1_0_0_0_0_00_000, 32'h1234, 32'h1234, 0, 32'h134, 5, 5, 6));
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(EW'(bubble()));
    checkE("mid_rst_async");
    rst = 1'b0;
    drive(32'h0052_8333, 32'h138);
    applyCheck("add_post_rst", mk(10'b1_0_0_0_0_00_000, 0, 0, 0, 32'h138, 5, 5, 6));
    drive(32'hFE73_AE23, 32'h13C);
    applyCheck("sw_post_rst", mk(10'b0_1_0_0_1_00_000, 0, 0, 32'hFFFF_FFFC, 32'h13C, 7, 7, 28));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
